// File: rtl/core_pkg.sv
// Shared types and constants for the fetch-side program counter logic.
// Latency: none (package only).
// Backpressure: none (package only).
package core_pkg;

    // Program counter sequencing states
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    localparam int ILEN_BYTES = 4;
    localparam int CLEN_BYTES = 2;

    // With compressed instructions only halfword alignment is required
    function automatic logic target_misaligned(input logic [1:0] lsb, input logic rvc_en);
        return rvc_en ? lsb[0] : (|lsb);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (trap > mret > redirect > halt > stall > increment) with alignment check.
// Latency: purely combinational.
// Backpressure: stall/halt hold the PC; trap, mret and redirect override stall.
// Optional macro PC_UNIT_RVC_EN: 2-byte increment for compressed instructions, target[0] alignment.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap_req,
    input  logic            i_mret_req,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_halt_req,
`ifdef PC_UNIT_RVC_EN
    input  logic            i_is_compressed,
`endif
    output logic [XLEN-1:0] o_pc_plus,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_fault,
    output logic [XLEN-1:0] o_fault_target,
    output logic            o_halt_take
);

`ifdef PC_UNIT_RVC_EN
    localparam logic RVC_EN = 1'b1;
    logic [XLEN-1:0] w_inc;
    assign w_inc = i_is_compressed ? XLEN'(CLEN_BYTES) : XLEN'(ILEN_BYTES);
`else
    localparam logic RVC_EN = 1'b0;
    logic [XLEN-1:0] w_inc;
    assign w_inc = XLEN'(ILEN_BYTES);
`endif

    logic w_mret_bad;
    logic w_redir_bad;

    // Sequential successor wraps modulo 2^XLEN
    assign o_pc_plus   = i_pc + w_inc;
    assign w_mret_bad  = target_misaligned(i_mepc[1:0], RVC_EN);
    assign w_redir_bad = target_misaligned(i_redirect_target[1:0], RVC_EN);

    // Priority select of the next PC; a misaligned target diverts to the trap vector
    always_comb begin
        o_next_pc      = i_pc;
        o_fault        = 1'b0;
        o_fault_target = '0;
        o_halt_take    = 1'b0;
        if (i_trap_req) begin
            o_next_pc = TRAP_VECTOR;
        end else if (i_mret_req) begin
            if (w_mret_bad) begin
                o_next_pc      = TRAP_VECTOR;
                o_fault        = 1'b1;
                o_fault_target = i_mepc;
            end else begin
                o_next_pc = i_mepc;
            end
        end else if (i_redirect_valid) begin
            if (w_redir_bad) begin
                o_next_pc      = TRAP_VECTOR;
                o_fault        = 1'b1;
                o_fault_target = i_redirect_target;
            end else begin
                o_next_pc = i_redirect_target;
            end
        end else if (i_halt_req) begin
            o_halt_take = 1'b1;
        end else if (!i_stall) begin
            o_next_pc = o_pc_plus;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with boot/run/halt sequencing and misaligned-target fault capture.
// Latency: requests sampled on a rising edge appear on pc right after that edge; pc_plus is combinational.
// Backpressure: stall holds pc in RUN; HALT freezes pc until resume_req. Optional macro PC_UNIT_RVC_EN.
module pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
    input  logic            resume_req,
`ifdef PC_UNIT_RVC_EN
    input  logic            is_compressed,
`endif
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            halted,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_halted;
    logic            r_misalign_fault;
    logic [XLEN-1:0] r_fault_addr;

    logic [XLEN-1:0] w_next_pc;
    logic            w_fault;
    logic [XLEN-1:0] w_fault_target;
    logic            w_halt_take;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .i_pc              (r_pc),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_trap_req        (trap_req),
        .i_mret_req        (mret_req),
        .i_mepc            (mepc),
        .i_halt_req        (halt_req),
`ifdef PC_UNIT_RVC_EN
        .i_is_compressed   (is_compressed),
`endif
        .o_pc_plus         (pc_plus),
        .o_next_pc         (w_next_pc),
        .o_fault           (w_fault),
        .o_fault_target    (w_fault_target),
        .o_halt_take       (w_halt_take)
    );

    // Boot/run/halt sequencing; pc only advances in RUN, outputs registered with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= PC_BOOT;
            r_pc             <= RESET_VECTOR;
            r_fetch_valid    <= 1'b0;
            r_halted         <= 1'b0;
            r_misalign_fault <= 1'b0;
            r_fault_addr     <= '0;
        end else begin
            r_misalign_fault <= 1'b0;
            case (r_state)
                PC_BOOT: begin
                    r_state       <= PC_RUN;
                    r_fetch_valid <= 1'b1;
                end
                PC_RUN: begin
                    r_pc             <= w_next_pc;
                    r_misalign_fault <= w_fault;
                    if (w_fault) begin
                        r_fault_addr <= w_fault_target;
                    end
                    if (w_halt_take) begin
                        r_state       <= PC_HALT;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                end
                PC_HALT: begin
                    if (resume_req) begin
                        r_state       <= PC_RUN;
                        r_fetch_valid <= 1'b1;
                        r_halted      <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= PC_BOOT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign pc             = r_pc;
    assign fetch_valid    = r_fetch_valid;
    assign halted         = r_halted;
    assign misalign_fault = r_misalign_fault;
    assign fault_addr     = r_fault_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: table of request vectors with expected post-edge state, checked via a queue.
// Latency: one edge per vector; reset and compressed-increment cases are hand-written sequences.
// Backpressure: stall/halt rows exercise the hold paths.
module tb_pc_unit;

`ifdef PC_UNIT_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_req = 1'b0;
    logic        mret_req = 1'b0;
    logic [31:0] mepc = '0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
`ifdef PC_UNIT_RVC_EN
    logic        is_compressed = 1'b0;
`endif
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        trap;
        logic        mret;
        logic [31:0] mepc;
        logic        halt;
        logic        resume;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_halted;
        logic        e_fault;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t tbl[26];
    vec_t sb[$];

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret_req        (mret_req),
        .mepc            (mepc),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
`ifdef PC_UNIT_RVC_EN
        .is_compressed   (is_compressed),
`endif
        .pc              (pc),
        .pc_plus         (pc_plus),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .misalign_fault  (misalign_fault),
        .fault_addr      (fault_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rt,
                                input logic tr, input logic mr, input logic [31:0] me,
                                input logic hr, input logic rs, input logic [31:0] epc,
                                input logic efv, input logic eh, input logic ef,
                                input logic [31:0] efa);
        vec_t v;
        v.stall = st; v.rv = rv; v.rt = rt; v.trap = tr; v.mret = mr; v.mepc = me;
        v.halt = hr; v.resume = rs; v.e_pc = epc; v.e_fv = efv; v.e_halted = eh;
        v.e_fault = ef; v.e_faddr = efa;
        return v;
    endfunction

    task automatic drive_idle();
        stall = 0; redirect_valid = 0; redirect_target = 0; trap_req = 0;
        mret_req = 0; mepc = 0; halt_req = 0; resume_req = 0;
`ifdef PC_UNIT_RVC_EN
        is_compressed = 0;
`endif
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        stall = v.stall; redirect_valid = v.rv; redirect_target = v.rt;
        trap_req = v.trap; mret_req = v.mret; mepc = v.mepc;
        halt_req = v.halt; resume_req = v.resume;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("row%0d_pc", idx), pc, e.e_pc);
        chk($sformatf("row%0d_pc_plus", idx), pc_plus, e.e_pc + 32'd4);
        chk($sformatf("row%0d_fetch_valid", idx), {31'd0, fetch_valid}, {31'd0, e.e_fv});
        chk($sformatf("row%0d_halted", idx), {31'd0, halted}, {31'd0, e.e_halted});
        chk($sformatf("row%0d_fault", idx), {31'd0, misalign_fault}, {31'd0, e.e_fault});
        chk($sformatf("row%0d_fault_addr", idx), fault_addr, e.e_faddr);
    endtask

    task automatic idle_edge(input string name, input logic [31:0] epc, input logic efv);
        @(posedge clk);
        #1;
        chk({name, "_pc"}, pc, epc);
        chk({name, "_fv"}, {31'd0, fetch_valid}, {31'd0, efv});
    endtask

    initial begin
        logic [31:0] fa5;
        fa5 = RVC ? 32'h0 : 32'h1002;
        //            st rv rt            tr mr mepc      hr rs  e_pc                            fv h  flt   faddr
        tbl[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0C,                          1, 0, 0,    32'h0);
        tbl[1]  = mk(1, 1, 32'h200,      1, 0, 32'h0,    0, 0, 32'h100,                         1, 0, 0,    32'h0);
        tbl[2]  = mk(1, 1, 32'h200,      0, 0, 32'h0,    0, 0, 32'h200,                         1, 0, 0,    32'h0);
        tbl[3]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h200,                         1, 0, 0,    32'h0);
        tbl[4]  = mk(0, 1, 32'h1002,     0, 0, 32'h0,    0, 0, RVC ? 32'h1002 : 32'h100,        1, 0, !RVC, fa5);
        tbl[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, RVC ? 32'h1006 : 32'h104,        1, 0, 0,    fa5);
        tbl[6]  = mk(0, 1, 32'h1004,     0, 0, 32'h0,    0, 0, 32'h1004,                        1, 0, 0,    fa5);
        tbl[7]  = mk(0, 1, 32'h300,      0, 1, 32'h80,   0, 0, 32'h80,                          1, 0, 0,    fa5);
        tbl[8]  = mk(1, 0, 32'h0,        0, 1, 32'h81,   0, 0, 32'h100,                         1, 0, 1,    32'h81);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h104,                         1, 0, 0,    32'h81);
        tbl[10] = mk(0, 1, 32'h1C,       0, 0, 32'h0,    0, 0, 32'h1C,                          1, 0, 0,    32'h81);
        tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h20,                          1, 0, 0,    32'h81);
        tbl[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[13] = mk(0, 1, 32'h400,      0, 0, 32'h0,    0, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[15] = mk(0, 1, 32'h402,      0, 0, 32'h0,    0, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[16] = mk(0, 0, 32'h0,        1, 1, 32'h81,   0, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[17] = mk(0, 1, 32'h400,      0, 0, 32'h0,    0, 0, 32'h20,                          0, 1, 0,    32'h81);
        tbl[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 32'h20,                          1, 0, 0,    32'h81);
        tbl[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h24,                          1, 0, 0,    32'h81);
        tbl[20] = mk(0, 1, 32'h40,       0, 0, 32'h0,    1, 0, 32'h40,                          1, 0, 0,    32'h81);
        tbl[21] = mk(1, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h40,                          0, 1, 0,    32'h81);
        tbl[22] = mk(0, 0, 32'h0,        1, 0, 32'h0,    0, 1, 32'h40,                          1, 0, 0,    32'h81);
        tbl[23] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,   0, 0, 32'hFFFF_FFFC,                   1, 0, 0,    32'h81);
        tbl[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,                           1, 0, 0,    32'h81);
        tbl[25] = mk(1, 1, 32'h40,       0, 0, 32'h0,    0, 0, 32'h40,                          1, 0, 0,    32'h81);

        drive_idle();
        // Reset from time zero, released away from the clock edge
        #2 rst = 1'b0;
        #10;
        chk("reset_pc", pc, 32'h0);
        chk("reset_fv", {31'd0, fetch_valid}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_fault", {31'd0, misalign_fault}, 32'd0);
        chk("reset_faddr", fault_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        idle_edge("boot_exit", 32'h0, 1'b1);
        idle_edge("run1", 32'h4, 1'b1);
        idle_edge("run2", 32'h8, 1'b1);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i], i);
        end

        // Asynchronous reset mid-run at pc 0x40 with a redirect pending
        redirect_valid = 1; redirect_target = 32'h200; stall = 1;
        #2 rst = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("midrst_faddr", fault_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_pc", pc, 32'h0);
        // BOOT cycle ignores every request
        trap_req = 1; mret_req = 1; mepc = 32'h81;
        rst = 1'b1;
        #1;
        chk("boot2_fv", {31'd0, fetch_valid}, 32'd0);
        idle_edge("boot2_exit", 32'h0, 1'b1);
        chk("boot2_fault", {31'd0, misalign_fault}, 32'd0);
        drive_idle();
        idle_edge("boot2_run1", 32'h4, 1'b1);
        idle_edge("boot2_run2", 32'h8, 1'b1);

        // Misaligned-fault pulse lasts exactly one cycle
        redirect_valid = 1; redirect_target = 32'h1003;
        @(posedge clk);
        #1;
        drive_idle();
        chk("pulse_hi", {31'd0, misalign_fault}, 32'd1);
        chk("pulse_faddr", fault_addr, 32'h1003);
        @(posedge clk);
        #1;
        chk("pulse_lo", {31'd0, misalign_fault}, 32'd0);
        chk("pulse_faddr_hold", fault_addr, 32'h1003);

`ifdef PC_UNIT_RVC_EN
        // Compressed increment at pc 0x10
        redirect_valid = 1; redirect_target = 32'h10;
        @(posedge clk);
        #1;
        drive_idle();
        is_compressed = 1;
        #1;
        chk("rvc_plus_at10", pc_plus, 32'h12);
        @(posedge clk);
        #1;
        chk("rvc_pc", pc, 32'h12);
        chk("rvc_plus", pc_plus, 32'h14);
        is_compressed = 0;
        #1;
        chk("rvc_plus4", pc_plus, 32'h16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle RISC-V core; the next generation of the basic PC register.
- Holds the fetch PC and selects the next PC from sequential increment, branch/jump redirect, trap entry, trap return and debug halt.
- Adds a boot/run/halt state machine and a misaligned-target fault capture.
- Feeds the instruction memory address and the PC+4 adder consumers (JAL/JALR write-back).

Parameters:
- XLEN, 32, PC and address width in bits (>= 16).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN-bit).
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or misaligned fault.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- stall  input  1  hold PC this cycle (no increment).
- redirect_valid  input  1  branch/jump taken.
- redirect_target  input  XLEN  branch/jump target.
- trap_req  input  1  exception/interrupt entry.
- mret_req  input  1  return from trap.
- mepc  input  XLEN  return address for mret.
- halt_req  input  1  debug halt request.
- resume_req  input  1  debug resume request.
- pc  output  XLEN  current fetch PC.
- pc_plus  output  XLEN  pc + 4 (combinational, modulo 2^XLEN).
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- halted  output  1  state == HALT.
- misalign_fault  output  1  one-cycle pulse: a redirect or mret target was misaligned.
- fault_addr  output  XLEN  last misaligned target captured.

Behaviour:
- Reset is asynchronous on rst low. It sets:
  - pc = RESET_VECTOR, state = BOOT
  - fetch_valid = 0, halted = 0, misalign_fault = 0, fault_addr = 0
- Reset asserted mid-operation aborts any pending event; no other register updates occur.
- States:
  - BOOT: one cycle after reset release. pc is held, fetch_valid = 0. Goes to RUN unconditionally; all requests in this cycle are ignored.
  - RUN: fetch_valid = 1. Next-PC priority, evaluated each rising edge, highest first:
    1. trap_req: pc <= TRAP_VECTOR.
    2. mret_req: pc <= mepc if aligned, else fault.
    3. redirect_valid: pc <= redirect_target if aligned, else fault.
    4. halt_req: pc is held, state <= HALT.
    5. stall: pc is held.
    6. Otherwise: pc <= pc + 4.
  - Trap, mret and redirect override stall.
  - halt_req is honoured only when none of trap_req, mret_req or redirect_valid is asserted; otherwise it must be held by the requester.
  - HALT: fetch_valid = 0, halted = 1, pc is frozen. All requests except resume_req are ignored. resume_req moves to RUN, and fetch resumes at the frozen pc the following cycle.
- Alignment: a target is misaligned when target[1:0] != 0. On a fault:
  - pc <= TRAP_VECTOR.
  - fault_addr <= the offending target.
  - misalign_fault = 1 for exactly the following cycle.
- fault_addr holds its value until the next fault or reset.
- Arithmetic: all PC arithmetic is XLEN bits and wraps silently. pc = all-ones minus 3 increments to 0.
- pc and pc_plus are valid in every state; consumers qualify them with fetch_valid.
- Latency: a request sampled at edge N is reflected on pc after edge N; there is no lookahead.

Optional Feature:
- Macro PC_UNIT_RVC_EN.
- When defined:
  - Adds input is_compressed (1 bit). In RUN with no other event, pc <= pc + 2 when is_compressed = 1, else pc + 4.
  - pc_plus follows the same 2/4 select.
  - The alignment check uses target[0] only.
- When undefined:
  - The is_compressed port does not exist.
  - Increment is always 4.
  - The alignment check uses target[1:0].

Decomposition:
- Shared package core_pkg holds:
  - the state enum (PC_BOOT, PC_RUN, PC_HALT)
  - the default RESET_VECTOR and TRAP_VECTOR constants
  - the instruction-length constants ILEN_BYTES = 4 and CLEN_BYTES = 2
- One sub-module, pc_next_sel: a combinational priority mux plus alignment check that produces next_pc, fault and fault target. pc_unit keeps the registers and the FSM.

Test Plan:
- Reset/boot: assert rst low mid-run at pc = 0x40, release → pc = 0x0, fetch_valid = 0 for one cycle, then pc = 0x4, 0x8 on successive edges.
- Priority: in one cycle assert trap_req = 1, redirect_valid = 1 (target 0x200) and stall = 1 → pc = 0x100, no fault. Next cycle redirect_valid alone with stall = 1 → pc = 0x200.
- Misaligned redirect: redirect_target = 0x1002 → pc = 0x100, misalign_fault high for exactly one cycle, fault_addr = 0x1002. Without PC_UNIT_RVC_EN, target 0x1004 → no fault.
- mret: mepc = 0x80 with mret_req → pc = 0x80. mepc = 0x81 → fault, fault_addr = 0x81.
- Halt/resume: halt_req at pc = 0x20 → halted = 1, fetch_valid = 0, pc stays 0x20 for 5 cycles with redirect_valid toggling. resume_req → RUN, then pc = 0x24.
- Wrap and RVC:
  - pc = 0xFFFF_FFFC increments to 0x0.
  - With PC_UNIT_RVC_EN and is_compressed = 1 at pc = 0x10 → pc = 0x12, pc_plus = 0x14.
  - With PC_UNIT_RVC_EN, target 0x1002 → no fault.
